// File: rtl/core_mem_arbiter_if.sv
// Request/response bus between the requester channels, the arbiter and the
// memory port. Channel i owns slice i of every packed per-channel field.
// The arbiter connects through the slave modport; the requesters and memory
// model connect through the master modport.
interface core_mem_arbiter_if #(
  parameter int P_CH = 2
);
  // Requester side
  logic [P_CH-1:0]    iREQ_REQ;
  logic [P_CH-1:0]    oREQ_LOCK;
  logic [2*P_CH-1:0]  iREQ_ORDER;
  logic [4*P_CH-1:0]  iREQ_MASK;
  logic [P_CH-1:0]    iREQ_RW;
  logic [32*P_CH-1:0] iREQ_ADDR;
  logic [32*P_CH-1:0] iREQ_DATA;
  logic [P_CH-1:0]    oREQ_VALID;
  logic [63:0]        oREQ_DATA;

  // Memory side
  logic               oMEM_REQ;
  logic               iMEM_LOCK;
  logic [1:0]         oMEM_ORDER;
  logic [3:0]         oMEM_MASK;
  logic               oMEM_RW;
  logic [31:0]        oMEM_ADDR;
  logic [31:0]        oMEM_DATA;
  logic               iMEM_VALID;
  logic [63:0]        iMEM_DATA;

  modport slave (
    input  iREQ_REQ, iREQ_ORDER, iREQ_MASK, iREQ_RW, iREQ_ADDR, iREQ_DATA,
    output oREQ_LOCK, oREQ_VALID, oREQ_DATA,
    output oMEM_REQ, oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_ADDR, oMEM_DATA,
    input  iMEM_LOCK, iMEM_VALID, iMEM_DATA
  );

  modport master (
    output iREQ_REQ, iREQ_ORDER, iREQ_MASK, iREQ_RW, iREQ_ADDR, iREQ_DATA,
    input  oREQ_LOCK, oREQ_VALID, oREQ_DATA,
    input  oMEM_REQ, oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_ADDR, oMEM_DATA,
    output iMEM_LOCK, iMEM_VALID, iMEM_DATA
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// N-requester round-robin memory port arbiter. One registered output stage
// feeds the memory bus at one request per cycle; an in-order tag FIFO records
// which channel issued each read so responses can be steered back.
module core_mem_arbiter #(
  parameter int P_CH    = 2,
  parameter int P_DEPTH = 4,
  parameter int P_CW    = $clog2(P_CH)
) (
  input  logic                         iCLOCK,
  input  logic                         inRESET,
  input  logic                         iRESET_SYNC,
  core_mem_arbiter_if.slave            bus,
  output logic [$clog2(P_DEPTH+1)-1:0] oPENDING,
  output logic                         oERR_ORPHAN
);

  localparam int P_AW = $clog2(P_DEPTH);
  localparam int P_PW = $clog2(P_DEPTH+1);

  // Output stage
  logic            r_memReq;
  logic [1:0]      r_memOrder;
  logic [3:0]      r_memMask;
  logic            r_memRw;
  logic [31:0]     r_memAddr;
  logic [31:0]     r_memData;

  // Round-robin pointer: last granted channel
  logic [P_CW-1:0] r_ptr;

  // Tag FIFO
  logic [P_CW-1:0] r_tagMem [P_DEPTH];
  logic [P_AW-1:0] r_wrPtr;
  logic [P_AW-1:0] r_rdPtr;
  logic [P_PW-1:0] r_count;

  // Response register and orphan flag
  logic [P_CH-1:0] r_rspValid;
  logic [63:0]     r_rspData;
  logic            r_orphan;

  logic            w_canLoad;
  logic            w_hasRoom;
  logic            w_grantValid;
  logic [P_CW-1:0] w_grantIdx;
  logic [P_CW-1:0] w_cand;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_orphanHit;

  // A read may only be granted while a tag slot is free right now; a pop in
  // the same cycle does not count, which keeps the full check purely registered.
  assign w_canLoad   = !r_memReq || !bus.iMEM_LOCK;
  assign w_hasRoom   = r_count < P_PW'(P_DEPTH);
  assign w_accept    = w_canLoad && w_grantValid;
  assign w_push      = w_accept && bus.iREQ_RW[w_grantIdx];
  assign w_pop       = bus.iMEM_VALID && (r_count != '0);
  assign w_orphanHit = bus.iMEM_VALID && (r_count == '0);

  // Round-robin search starting one past the last granted channel
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_cand       = '0;
    for (int k = 1; k <= P_CH; k++) begin
      w_cand = P_CW'((int'(r_ptr) + k) % P_CH);
      if (!w_grantValid && bus.iREQ_REQ[w_cand] &&
          (!bus.iREQ_RW[w_cand] || w_hasRoom)) begin
        w_grantValid = 1'b1;
        w_grantIdx   = w_cand;
      end
    end
  end

  // Every channel except an accepted one is told to hold its request
  always_comb begin
    bus.oREQ_LOCK = '1;
    for (int i = 0; i < P_CH; i++) begin
      if (w_accept && (w_grantIdx == P_CW'(i))) begin
        bus.oREQ_LOCK[i] = 1'b0;
      end
    end
  end

  // Output stage: load the granted request, drop valid once memory takes it
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_memReq   <= 1'b0;
      r_memOrder <= '0;
      r_memMask  <= '0;
      r_memRw    <= 1'b0;
      r_memAddr  <= '0;
      r_memData  <= '0;
      r_ptr      <= P_CW'(P_CH-1);
    end else if (iRESET_SYNC) begin
      r_memReq   <= 1'b0;
      r_memOrder <= '0;
      r_memMask  <= '0;
      r_memRw    <= 1'b0;
      r_memAddr  <= '0;
      r_memData  <= '0;
      r_ptr      <= P_CW'(P_CH-1);
    end else if (w_accept) begin
      r_memReq   <= 1'b1;
      r_memOrder <= bus.iREQ_ORDER[int'(w_grantIdx)*2 +: 2];
      r_memMask  <= bus.iREQ_MASK[int'(w_grantIdx)*4 +: 4];
      r_memRw    <= bus.iREQ_RW[w_grantIdx];
      r_memAddr  <= bus.iREQ_ADDR[int'(w_grantIdx)*32 +: 32];
      r_memData  <= bus.iREQ_DATA[int'(w_grantIdx)*32 +: 32];
      r_ptr      <= w_grantIdx;
    end else if (w_canLoad) begin
      r_memReq   <= 1'b0;
    end
  end

  // Tag FIFO storage; contents need no reset since the count gates reads
  always_ff @(posedge iCLOCK) begin
    if (w_push) begin
      r_tagMem[r_wrPtr] <= w_grantIdx;
    end
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (iRESET_SYNC) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Response steering: one-cycle strobe to the channel at the FIFO head
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_rspValid <= '0;
      r_rspData  <= '0;
      r_orphan   <= 1'b0;
    end else if (iRESET_SYNC) begin
      r_rspValid <= '0;
      r_rspData  <= '0;
      r_orphan   <= 1'b0;
    end else begin
      r_rspValid <= '0;
      if (w_pop) begin
        r_rspValid <= P_CH'(1) << r_tagMem[r_rdPtr];
        r_rspData  <= bus.iMEM_DATA;
      end
      if (w_orphanHit) begin
        r_orphan <= 1'b1;
      end
    end
  end

  assign bus.oMEM_REQ   = r_memReq;
  assign bus.oMEM_ORDER = r_memOrder;
  assign bus.oMEM_MASK  = r_memMask;
  assign bus.oMEM_RW    = r_memRw;
  assign bus.oMEM_ADDR  = r_memAddr;
  assign bus.oMEM_DATA  = r_memData;
  assign bus.oREQ_VALID = r_rspValid;
  assign bus.oREQ_DATA  = r_rspData;
  assign oPENDING       = r_count;
  assign oERR_ORPHAN    = r_orphan;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter with two channels and a four-deep tag
// FIFO. Expected values are worked out by hand for each step.
module tb_core_mem_arbiter;

  localparam int P_CH    = 2;
  localparam int P_DEPTH = 4;

  logic       clock;
  logic       inRESET;
  logic       iRESET_SYNC;
  logic [2:0] pending;
  logic       errOrphan;

  int compareCount;
  int mismatchCount;

  core_mem_arbiter_if #(.P_CH(P_CH)) bus ();

  core_mem_arbiter #(.P_CH(P_CH), .P_DEPTH(P_DEPTH)) dut (
    .iCLOCK      (clock),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .bus         (bus),
    .oPENDING    (pending),
    .oERR_ORPHAN (errOrphan)
  );

  // Free-running 10-time-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive every requester and memory input, then let combinational logic settle
  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] rw,
                               input logic [31:0] addr0, input logic [31:0] addr1,
                               input logic memLock, input logic memValid,
                               input logic [63:0] memData);
    bus.iREQ_REQ   = req;
    bus.iREQ_RW    = rw;
    bus.iREQ_ORDER = 4'b1010;
    bus.iREQ_MASK  = 8'hFF;
    bus.iREQ_ADDR  = {addr1, addr0};
    bus.iREQ_DATA  = {addr1 ^ 32'hA5A5_0000, addr0 ^ 32'hA5A5_0000};
    bus.iMEM_LOCK  = memLock;
    bus.iMEM_VALID = memValid;
    bus.iMEM_DATA  = memData;
    #1;
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    inRESET       = 1'b0;
    iRESET_SYNC   = 1'b0;
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 64'h0);
    repeat (3) step();
    inRESET = 1'b1;
    step();

    // Reset state
    checkOutput("rst_memReq", 64'(bus.oMEM_REQ), 64'd0);
    checkOutput("rst_memAddr", 64'(bus.oMEM_ADDR), 64'd0);
    checkOutput("rst_reqValid", 64'(bus.oREQ_VALID), 64'd0);
    checkOutput("rst_reqData", bus.oREQ_DATA, 64'd0);
    checkOutput("rst_pending", 64'(pending), 64'd0);
    checkOutput("rst_orphan", 64'(errOrphan), 64'd0);

    // Single read from channel 0 and its response
    applyStimulus(2'b01, 2'b11, 32'h100, 32'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("t1_lock", 64'(bus.oREQ_LOCK), 64'b10);
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 64'h0);
    checkOutput("t1_memReq", 64'(bus.oMEM_REQ), 64'd1);
    checkOutput("t1_memAddr", 64'(bus.oMEM_ADDR), 64'h100);
    checkOutput("t1_memRw", 64'(bus.oMEM_RW), 64'd1);
    checkOutput("t1_memOrder", 64'(bus.oMEM_ORDER), 64'b10);
    checkOutput("t1_pending", 64'(pending), 64'd1);
    step();
    checkOutput("t1_memReqDrop", 64'(bus.oMEM_REQ), 64'd0);
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 64'h1122334455667788);
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 64'h0);
    checkOutput("t1_rspValid", 64'(bus.oREQ_VALID), 64'b01);
    checkOutput("t1_rspData", bus.oREQ_DATA, 64'h1122334455667788);
    checkOutput("t1_pendingEmpty", 64'(pending), 64'd0);
    step();
    checkOutput("t1_rspStrobeEnd", 64'(bus.oREQ_VALID), 64'd0);

    // Both channels reading every cycle: grants alternate, stage stays full
    applyStimulus(2'b11, 2'b11, 32'h200, 32'h300, 1'b0, 1'b0, 64'h0);
    checkOutput("t2_lockA", 64'(bus.oREQ_LOCK), 64'b01);
    step();
    applyStimulus(2'b11, 2'b11, 32'h200, 32'h300, 1'b0, 1'b1, 64'hAAAA);
    checkOutput("t2_addrA", 64'(bus.oMEM_ADDR), 64'h300);
    checkOutput("t2_lockB", 64'(bus.oREQ_LOCK), 64'b10);
    step();
    checkOutput("t2_memReqB", 64'(bus.oMEM_REQ), 64'd1);
    checkOutput("t2_addrB", 64'(bus.oMEM_ADDR), 64'h200);
    checkOutput("t2_rspB", 64'(bus.oREQ_VALID), 64'b10);
    checkOutput("t2_pendingB", 64'(pending), 64'd1);
    checkOutput("t2_lockC", 64'(bus.oREQ_LOCK), 64'b01);
    step();
    checkOutput("t2_memReqC", 64'(bus.oMEM_REQ), 64'd1);
    checkOutput("t2_addrC", 64'(bus.oMEM_ADDR), 64'h300);
    checkOutput("t2_rspC", 64'(bus.oREQ_VALID), 64'b01);
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 64'hBBBB);
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 64'h0);
    checkOutput("t2_memReqIdle", 64'(bus.oMEM_REQ), 64'd0);
    checkOutput("t2_rspD", 64'(bus.oREQ_VALID), 64'b10);
    checkOutput("t2_pendingD", 64'(pending), 64'd0);

    // Channel 1 fills the tag FIFO; a write from channel 0 still passes
    for (int i = 0; i < P_DEPTH; i++) begin
      applyStimulus(2'b10, 2'b10, 32'h0, 32'h900 + 32'(i * 4), 1'b0, 1'b0, 64'h0);
      checkOutput("t3_fillLock", 64'(bus.oREQ_LOCK), 64'b01);
      step();
      checkOutput("t3_fillPending", 64'(pending), 64'(i + 1));
    end
    applyStimulus(2'b11, 2'b10, 32'h800, 32'h910, 1'b0, 1'b0, 64'h0);
    checkOutput("t3_fullLock", 64'(bus.oREQ_LOCK), 64'b10);
    step();
    checkOutput("t3_writeAddr", 64'(bus.oMEM_ADDR), 64'h800);
    checkOutput("t3_writeRw", 64'(bus.oMEM_RW), 64'd0);
    checkOutput("t3_writeData", 64'(bus.oMEM_DATA), 64'hA5A5_0800);
    checkOutput("t3_pendingFull", 64'(pending), 64'd4);
    applyStimulus(2'b10, 2'b10, 32'h0, 32'h910, 1'b0, 1'b1, 64'hC0);
    checkOutput("t3_noBypassLock", 64'(bus.oREQ_LOCK), 64'b11);
    step();
    applyStimulus(2'b10, 2'b10, 32'h0, 32'h910, 1'b0, 1'b0, 64'h0);
    checkOutput("t3_popRsp", 64'(bus.oREQ_VALID), 64'b10);
    checkOutput("t3_pendingPop", 64'(pending), 64'd3);
    checkOutput("t3_unblockLock", 64'(bus.oREQ_LOCK), 64'b01);
    step();
    checkOutput("t3_unblockAddr", 64'(bus.oMEM_ADDR), 64'h910);
    checkOutput("t3_refill", 64'(pending), 64'd4);
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 64'hD0);
    for (int i = 0; i < P_DEPTH; i++) begin
      step();
      checkOutput("t3_drainRsp", 64'(bus.oREQ_VALID), 64'b10);
    end
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 64'h0);
    checkOutput("t3_drained", 64'(pending), 64'd0);

    // Memory busy: stage holds, every channel locked, nothing lost
    applyStimulus(2'b01, 2'b00, 32'h400, 32'h0, 1'b0, 1'b0, 64'h0);
    step();
    applyStimulus(2'b11, 2'b00, 32'h404, 32'h500, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4_heldReq", 64'(bus.oMEM_REQ), 64'd1);
      checkOutput("t4_heldAddr", 64'(bus.oMEM_ADDR), 64'h400);
      checkOutput("t4_heldData", 64'(bus.oMEM_DATA), 64'hA5A5_0400);
      checkOutput("t4_allLocked", 64'(bus.oREQ_LOCK), 64'b11);
      step();
    end
    applyStimulus(2'b11, 2'b00, 32'h404, 32'h500, 1'b0, 1'b0, 64'h0);
    checkOutput("t4_releaseAddr", 64'(bus.oMEM_ADDR), 64'h400);
    checkOutput("t4_releaseLock", 64'(bus.oREQ_LOCK), 64'b01);
    step();
    applyStimulus(2'b01, 2'b00, 32'h404, 32'h0, 1'b0, 1'b0, 64'h0);
    checkOutput("t4_secondAddr", 64'(bus.oMEM_ADDR), 64'h500);
    checkOutput("t4_secondLock", 64'(bus.oREQ_LOCK), 64'b10);
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 64'h0);
    checkOutput("t4_thirdAddr", 64'(bus.oMEM_ADDR), 64'h404);
    step();

    // Interleaved reads with push and pop overlapping
    applyStimulus(2'b01, 2'b01, 32'h600, 32'h0, 1'b0, 1'b0, 64'h0);
    step();
    applyStimulus(2'b10, 2'b10, 32'h0, 32'h700, 1'b0, 1'b1, 64'hD0D0_0000_0000_0001);
    checkOutput("t5_pendingBefore", 64'(pending), 64'd1);
    step();
    applyStimulus(2'b01, 2'b01, 32'h604, 32'h0, 1'b0, 1'b1, 64'hD1D1_0000_0000_0002);
    checkOutput("t5_rsp0", 64'(bus.oREQ_VALID), 64'b01);
    checkOutput("t5_data0", bus.oREQ_DATA, 64'hD0D0_0000_0000_0001);
    checkOutput("t5_pushPopSame", 64'(pending), 64'd1);
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 64'hD2D2_0000_0000_0003);
    checkOutput("t5_rsp1", 64'(bus.oREQ_VALID), 64'b10);
    checkOutput("t5_data1", bus.oREQ_DATA, 64'hD1D1_0000_0000_0002);
    checkOutput("t5_pendingMid", 64'(pending), 64'd1);
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 64'h0);
    checkOutput("t5_rsp2", 64'(bus.oREQ_VALID), 64'b01);
    checkOutput("t5_data2", bus.oREQ_DATA, 64'hD2D2_0000_0000_0003);
    checkOutput("t5_pendingEnd", 64'(pending), 64'd0);

    // Reset with reads outstanding, then a late response becomes an orphan
    applyStimulus(2'b01, 2'b01, 32'hA00, 32'h0, 1'b0, 1'b0, 64'h0);
    step();
    step();
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 64'h0);
    checkOutput("t6_pendingTwo", 64'(pending), 64'd2);
    inRESET = 1'b0;
    #1;
    checkOutput("t6_asyncPending", 64'(pending), 64'd0);
    checkOutput("t6_asyncMemReq", 64'(bus.oMEM_REQ), 64'd0);
    step();
    inRESET = 1'b1;
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 64'hEEEE);
    step();
    applyStimulus(2'b11, 2'b11, 32'hB00, 32'hC00, 1'b0, 1'b0, 64'h0);
    checkOutput("t6_noStrobe", 64'(bus.oREQ_VALID), 64'd0);
    checkOutput("t6_orphan", 64'(errOrphan), 64'd1);
    checkOutput("t6_pendingZero", 64'(pending), 64'd0);
    checkOutput("t6_ptrReset", 64'(bus.oREQ_LOCK), 64'b10);
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 64'h0);
    step();
    checkOutput("t6_orphanSticky", 64'(errOrphan), 64'd1);
    iRESET_SYNC = 1'b1;
    step();
    iRESET_SYNC = 1'b0;
    checkOutput("t6_syncClearsOrphan", 64'(errOrphan), 64'd0);
    checkOutput("t6_syncMemReq", 64'(bus.oMEM_REQ), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
